eth_header_builder: RTL and testbench
=====================================

ETH_HEADER_BUILDER -- requirements
Module: eth_header_builder

Interface
REQ-001 The block SHALL have parameter VLAN_TPID, default 16'h8100, TPID inserted when VLAN tagging is requested.
REQ-002 The block SHALL have parameter MIN_ETHERTYPE, default 16'h0600, smallest legal raw EtherType value.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 hdr_valid  input  1  header request present.
REQ-006 hdr_ready  output  1  block can accept a header request.
REQ-007 dst_mac  input  48  destination MAC; bits [47:40] are transmitted first.
REQ-008 src_mac  input  48  source MAC; bits [47:40] are transmitted first.
REQ-009 vlan_en  input  1  insert an 802.1Q tag.
REQ-010 vlan_tci  input  16  tag control info (PCP/DEI/VID).
REQ-011 proto_sel  input  2  0=IPv4, 1=IPv6, 2=ARP, 3=raw.
REQ-012 raw_ethertype  input  16  EtherType used when proto_sel=3.
REQ-013 out_data  output  8  header byte.
REQ-014 out_valid  output  1  out_data is valid.
REQ-015 out_ready  input  1  downstream accepts the byte.
REQ-016 out_last  output  1  final header byte.
REQ-017 hdr_len  output  5  length of the header in flight: 14 or 18.
REQ-018 type_err  output  1  one-cycle pulse when a raw EtherType is illegal.

Function
REQ-019 The block SHALL implement an FSM with states IDLE, DST, SRC, VLAN, TYPE.
REQ-020 hdr_ready SHALL be 1 only in IDLE, and the request SHALL be accepted when hdr_valid and hdr_ready are both 1.
REQ-021 On acceptance, all request inputs SHALL be latched, and input changes afterwards SHALL have no effect on the header in flight.
REQ-022 The EtherType SHALL be resolved at acceptance: 0x0800 for IPv4, 0x86DD for IPv6, 0x0806 for ARP, raw_ethertype for raw.
REQ-023 If proto_sel=3 and raw_ethertype < MIN_ETHERTYPE, the request SHALL be dropped: type_err pulses for one cycle, the FSM stays in IDLE and no bytes are emitted.
REQ-024 On a legal acceptance, the FSM SHALL move to DST, and out_valid SHALL be 1 in the next cycle (latency 1 from acceptance to the first byte).
REQ-025 The byte order SHALL be: 6 dst bytes, 6 src bytes, then, only if vlan_en, TPID MSB/LSB and TCI MSB/LSB, then EtherType MSB/LSB.
REQ-026 A 3-bit byte index SHALL select the byte within a field and SHALL reset to 0 at every field change.
REQ-027 A byte SHALL advance only when out_valid and out_ready are both 1.
REQ-028 While out_ready=0, out_data, out_last and the state SHALL hold stable.
REQ-029 out_valid SHALL never drop before its byte is accepted.
REQ-030 out_last SHALL be 1 only on the EtherType LSB.
REQ-031 Acceptance of the byte marked out_last SHALL return the FSM to IDLE, with hdr_ready=1 on the following cycle; there is no same-cycle back-to-back acceptance.
REQ-032 hdr_len SHALL be 18 if the latched vlan_en=1, else 14, and SHALL be valid from the first byte until out_last is accepted.
REQ-033 hdr_len SHALL be 0 in IDLE.
REQ-034 out_data SHALL be 8'h00 when out_valid=0.

Reset
REQ-035 While rst_n=0 at a clock edge, the block SHALL enter IDLE with byte index 0, out_valid=0, out_last=0, out_data=0, hdr_len=0, type_err=0 and hdr_ready=0.
REQ-036 hdr_ready SHALL become 1 on the first clock after rst_n returns to 1.
REQ-037 A reset asserted mid-header SHALL abort the header immediately, with no completion and no out_last.

Verification
REQ-038 Scenario 1: IPv4, vlan_en=0, dst=FF:FF:FF:FF:FF:FF, src=00:11:22:33:44:55, out_ready=1 -> exactly 14 bytes FF×6, 00 11 22 33 44 55, 08 00; out_last only on byte 14; hdr_len=14.
REQ-039 Scenario 2: IPv6, vlan_en=1, vlan_tci=16'h6064 -> exactly 18 bytes; bytes 13-16 are 81 00 60 64; bytes 17-18 are 86 DD; hdr_len=18.
REQ-040 Scenario 3: ARP with out_ready toggled randomly and inputs changed after acceptance -> byte sequence identical to the ready-always case; bytes 13-14 are 08 06; no byte duplicated or dropped.
REQ-041 Scenario 4: raw_ethertype=16'h05DC with proto_sel=3 -> type_err=1 for one cycle, out_valid stays 0, hdr_ready stays 1; raw 16'h88CC -> last bytes are 88 CC.
REQ-042 Scenario 5: hdr_valid held high for two requests -> second request accepted only after out_last is accepted, with exactly one idle cycle (hdr_ready=1, out_valid=0) between headers.
REQ-043 Scenario 6: rst_n=0 at byte 7 -> on the next edge out_valid=0 and hdr_len=0, and a new request afterwards emits a complete, correct header.

Source files
------------

// File: rtl/eth_header_builder.sv
// +--------------------------------------------------------------------------+
// | eth_header_builder                                                       |
// | Serialises an Ethernet II header (optional 802.1Q tag) as a byte stream. |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module eth_header_builder #(
  parameter logic [15:0] VLAN_TPID     = 16'h8100,
  parameter logic [15:0] MIN_ETHERTYPE = 16'h0600
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hdr_valid,
  output logic        hdr_ready,
  input  logic [47:0] dst_mac,
  input  logic [47:0] src_mac,
  input  logic        vlan_en,
  input  logic [15:0] vlan_tci,
  input  logic [1:0]  proto_sel,
  input  logic [15:0] raw_ethertype,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic [4:0]  hdr_len,
  output logic        type_err
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DST  = 3'd1,
    SRC  = 3'd2,
    VLAN = 3'd3,
    TYPE = 3'd4
  } state_t;

  localparam logic [15:0] c_type_ipv4 = 16'h0800;
  localparam logic [15:0] c_type_ipv6 = 16'h86DD;
  localparam logic [15:0] c_type_arp  = 16'h0806;

  state_t      r_state;
  state_t      w_state_next;
  logic [2:0]  r_idx;
  logic [2:0]  w_idx_next;
  logic [47:0] r_dst;
  logic [47:0] r_src;
  logic        r_vlan_en;
  logic [15:0] r_tci;
  logic [15:0] r_etype;
  logic        r_type_err;
  logic        r_init;

  logic [15:0] w_etype;
  logic        w_illegal;
  logic        w_accept;
  logic        w_fire;
  logic        w_field_end;
  logic [2:0]  w_rev;
  logic [1:0]  w_vrev;
  logic [31:0] w_vlan_word;

  always_comb begin
    w_etype = raw_ethertype;
    case (proto_sel)
      2'd0:    w_etype = c_type_ipv4;
      2'd1:    w_etype = c_type_ipv6;
      2'd2:    w_etype = c_type_arp;
      default: w_etype = raw_ethertype;
    endcase
  end

  assign w_illegal   = (proto_sel == 2'd3) && (raw_ethertype < MIN_ETHERTYPE);
  // r_init keeps hdr_ready low during reset and for the edge that releases it
  assign hdr_ready   = (r_state == IDLE) && r_init;
  assign w_accept    = hdr_valid && hdr_ready;
  assign out_valid   = (r_state != IDLE);
  assign w_fire      = out_valid && out_ready;
  assign hdr_len     = out_valid ? (r_vlan_en ? 5'd18 : 5'd14) : 5'd0;
  assign type_err    = r_type_err;
  assign w_rev       = 3'd5 - r_idx;
  assign w_vrev      = 2'd3 - r_idx[1:0];
  assign w_vlan_word = {VLAN_TPID, r_tci};

  always_comb begin
    out_data     = 8'h00;
    out_last     = 1'b0;
    w_field_end  = 1'b0;
    w_state_next = r_state;
    w_idx_next   = r_idx;
    case (r_state)
      IDLE: begin
        if (w_accept && !w_illegal) begin
          w_state_next = DST;
          w_idx_next   = 3'd0;
        end
      end
      DST: begin
        out_data    = r_dst[{w_rev, 3'b000} +: 8];
        w_field_end = (r_idx == 3'd5);
        if (w_fire && w_field_end) w_state_next = SRC;
      end
      SRC: begin
        out_data    = r_src[{w_rev, 3'b000} +: 8];
        w_field_end = (r_idx == 3'd5);
        if (w_fire && w_field_end) w_state_next = r_vlan_en ? VLAN : TYPE;
      end
      VLAN: begin
        out_data    = w_vlan_word[{w_vrev, 3'b000} +: 8];
        w_field_end = (r_idx == 3'd3);
        if (w_fire && w_field_end) w_state_next = TYPE;
      end
      TYPE: begin
        out_data    = r_idx[0] ? r_etype[7:0] : r_etype[15:8];
        w_field_end = (r_idx == 3'd1);
        out_last    = w_field_end;
        if (w_fire && w_field_end) w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
        w_idx_next   = 3'd0;
      end
    endcase
    if (w_fire) w_idx_next = w_field_end ? 3'd0 : r_idx + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_idx      <= 3'd0;
      r_type_err <= 1'b0;
      r_init     <= 1'b0;
      r_dst      <= 48'd0;
      r_src      <= 48'd0;
      r_vlan_en  <= 1'b0;
      r_tci      <= 16'd0;
      r_etype    <= 16'd0;
    end else begin
      r_state    <= w_state_next;
      r_idx      <= w_idx_next;
      r_init     <= 1'b1;
      r_type_err <= w_accept && w_illegal;
      if (w_accept && !w_illegal) begin
        r_dst     <= dst_mac;
        r_src     <= src_mac;
        r_vlan_en <= vlan_en;
        r_tci     <= vlan_tci;
        r_etype   <= w_etype;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_eth_header_builder.sv
// +--------------------------------------------------------------------------+
// | tb_eth_header_builder                                                    |
// | Directed table-driven bench for eth_header_builder.                      |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_eth_header_builder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hdr_valid = 1'b0;
  logic        hdr_ready;
  logic [47:0] dst_mac = '0;
  logic [47:0] src_mac = '0;
  logic        vlan_en = 1'b0;
  logic [15:0] vlan_tci = '0;
  logic [1:0]  proto_sel = '0;
  logic [15:0] raw_ethertype = '0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_last;
  logic [4:0]  hdr_len;
  logic        type_err;

  int total = 0;
  int bad   = 0;

  eth_header_builder #(
    .VLAN_TPID    (16'h8100),
    .MIN_ETHERTYPE(16'h0600)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hdr_valid    (hdr_valid),
    .hdr_ready    (hdr_ready),
    .dst_mac      (dst_mac),
    .src_mac      (src_mac),
    .vlan_en      (vlan_en),
    .vlan_tci     (vlan_tci),
    .proto_sel    (proto_sel),
    .raw_ethertype(raw_ethertype),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .hdr_len      (hdr_len),
    .type_err     (type_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] dst;
    logic [47:0] src;
    logic        vlan;
    logic [15:0] tci;
    logic [1:0]  proto;
    logic [15:0] raw;
    logic        err;
    int          len;
    logic [15:0] etype;
    logic        rnd;
    logic        chg;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_req(input vec_t v);
    dst_mac       = v.dst;
    src_mac       = v.src;
    vlan_en       = v.vlan;
    vlan_tci      = v.tci;
    proto_sel     = v.proto;
    raw_ethertype = v.raw;
    hdr_valid     = 1'b1;
  endtask

  // Starts on the falling edge right after acceptance; ends on the falling edge after the last byte.
  task automatic collect(input vec_t v);
    logic [7:0] e[18];
    logic [7:0] held;
    bit pend;
    int n, cnt, cyc;
    n = v.len;
    for (int i = 0; i < 6; i++) begin
      e[i]     = v.dst[47-8*i -: 8];
      e[6 + i] = v.src[47-8*i -: 8];
    end
    if (v.vlan) begin
      e[12] = 8'h81;
      e[13] = 8'h00;
      e[14] = v.tci[15:8];
      e[15] = v.tci[7:0];
    end
    e[n-2] = v.etype[15:8];
    e[n-1] = v.etype[7:0];
    cnt = 0; cyc = 0; pend = 0; held = 8'h00;
    while (cnt < n && cyc < 300) begin
      chk("out_valid", out_valid, 1'b1);
      chk("hdr_ready_busy", hdr_ready, 1'b0);
      chk("hdr_len", hdr_len, n[4:0]);
      chk("out_last", out_last, (cnt == n - 1));
      if (pend) chk("hold_data", out_data, held);
      out_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_ready) begin
        chk($sformatf("byte%0d", cnt + 1), out_data, e[cnt]);
        cnt++;
        pend = 0;
      end else begin
        held = out_data;
        pend = 1;
      end
      @(negedge clk);
      cyc++;
    end
    if (cnt < n) chk("byte_timeout", cnt, n);
    out_ready = 1'b1;
  endtask

  task automatic chk_idle();
    chk("idle_valid", out_valid, 1'b0);
    chk("idle_ready", hdr_ready, 1'b1);
    chk("idle_len", hdr_len, 5'd0);
    chk("idle_data", out_data, 8'h00);
    chk("idle_last", out_last, 1'b0);
  endtask

  task automatic run_hdr(input vec_t v);
    @(negedge clk);
    drive_req(v);
    chk("req_ready", hdr_ready, 1'b1);
    @(negedge clk);
    hdr_valid = 1'b0;
    if (v.chg) begin
      dst_mac       = ~v.dst;
      src_mac       = ~v.src;
      vlan_en       = ~v.vlan;
      vlan_tci      = 16'hFFFF;
      proto_sel     = 2'd3;
      raw_ethertype = 16'h0001;
    end
    if (v.err) begin
      chk("type_err_pulse", type_err, 1'b1);
      chk("err_no_valid", out_valid, 1'b0);
      chk("err_ready", hdr_ready, 1'b1);
      @(negedge clk);
      chk("type_err_clear", type_err, 1'b0);
      chk("err_no_valid2", out_valid, 1'b0);
    end else begin
      chk("no_type_err", type_err, 1'b0);
      collect(v);
      chk_idle();
    end
  endtask

  initial begin
    //         dst                 src                 vlan  tci       proto raw       err   len etype     rnd   chg
    tbl[0] = '{48'hFFFF_FFFF_FFFF, 48'h0011_2233_4455, 1'b0, 16'h0000, 2'd0, 16'h0000, 1'b0, 14, 16'h0800, 1'b0, 1'b0};
    tbl[1] = '{48'h0A0B_0C0D_0E0F, 48'h1020_3040_5060, 1'b1, 16'h6064, 2'd1, 16'h0000, 1'b0, 18, 16'h86DD, 1'b0, 1'b0};
    tbl[2] = '{48'h1234_5678_9ABC, 48'hDEF0_1234_5678, 1'b0, 16'h0000, 2'd2, 16'h0000, 1'b0, 14, 16'h0806, 1'b1, 1'b1};
    tbl[3] = '{48'h1111_1111_1111, 48'h2222_2222_2222, 1'b0, 16'h0000, 2'd3, 16'h05DC, 1'b1, 14, 16'h0000, 1'b0, 1'b0};
    tbl[4] = '{48'hA1A2_A3A4_A5A6, 48'hB1B2_B3B4_B5B6, 1'b1, 16'hE00A, 2'd3, 16'h88CC, 1'b0, 18, 16'h88CC, 1'b1, 1'b0};
    tbl[5] = '{48'h0102_0304_0506, 48'h0708_090A_0B0C, 1'b0, 16'h0000, 2'd3, 16'h0600, 1'b0, 14, 16'h0600, 1'b0, 1'b0};
    tbl[6] = '{48'h3333_3333_3333, 48'h4444_4444_4444, 1'b1, 16'h1234, 2'd3, 16'h05FF, 1'b1, 18, 16'h0000, 1'b0, 1'b0};
    tbl[7] = '{48'hCAFE_BABE_0001, 48'hDEAD_BEEF_0002, 1'b1, 16'h3FFF, 2'd0, 16'h0000, 1'b0, 18, 16'h0800, 1'b1, 1'b1};

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_ready", hdr_ready, 1'b0);
    chk("rst_len", hdr_len, 5'd0);
    chk("rst_data", out_data, 8'h00);
    chk("rst_last", out_last, 1'b0);
    chk("rst_type_err", type_err, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", hdr_ready, 1'b1);

    for (int k = 0; k < 8; k++) run_hdr(tbl[k]);

    // Two requests with hdr_valid held high: one idle cycle between headers.
    @(negedge clk);
    drive_req(tbl[0]);
    chk("b2b_ready1", hdr_ready, 1'b1);
    @(negedge clk);
    collect(tbl[0]);
    chk("b2b_gap_ready", hdr_ready, 1'b1);
    chk("b2b_gap_valid", out_valid, 1'b0);
    @(negedge clk);
    hdr_valid = 1'b0;
    collect(tbl[0]);
    chk_idle();

    // Reset while the seventh byte is presented aborts the header.
    @(negedge clk);
    drive_req(tbl[1]);
    @(negedge clk);
    hdr_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_byte7", out_data, 8'h10);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_valid", out_valid, 1'b0);
    chk("abort_len", hdr_len, 5'd0);
    chk("abort_last", out_last, 1'b0);
    chk("abort_ready", hdr_ready, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready_back", hdr_ready, 1'b1);
    run_hdr(tbl[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
